read_pointer_handler: RTL and testbench

- Read-side pointer logic of the async FIFO, in the consumer (rx) clock domain.
- Sits directly downstream of the write-side pointer handler. It consumes the write handler's registered gray write pointer after the 2-flop synchronizer.
- Drives the RAM read address, empty and almost_empty, and a read-domain occupancy level.
- Registers the gray read pointer so the write handler can synchronize it for its full detection.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/graycode_decoder.sv | 17 +
 rtl/read_pointer_handler.sv | 68 ++++++
 tb/tb_read_pointer_handler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async FIFO helpers: gray encode/decode functions.
// Functions work on a 32-bit container; callers size the result with a cast.
package fifo_pkg;

  localparam int GRAY_W = 32;

  function automatic logic [GRAY_W-1:0] gray_encode(
    input logic [GRAY_W-1:0] bin
  );
    logic [GRAY_W-1:0] g;
    g[GRAY_W-1] = bin[GRAY_W-1];
    for (int i = 0; i < GRAY_W-1; i++) begin
      g[i] = bin[i] ^ bin[i+1];
    end
    return g;
  endfunction

  // Zero upper bits decode to zero, so any narrower width
  // zero-extended into the container decodes correctly.
  function automatic logic [GRAY_W-1:0] gray_decode(
    input logic [GRAY_W-1:0] gray
  );
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/graycode_decoder.sv
// Gray to binary converter, combinational.
// Ports: i_gray (width) in, o_bin (width) out.
module graycode_decoder
  import fifo_pkg::*;
#(
  parameter int width = 4
) (
  input  logic [width-1:0] i_gray,
  output logic [width-1:0] o_bin
);

  logic [GRAY_W-1:0] w_bin_full;

  assign w_bin_full = gray_decode(GRAY_W'(i_gray));
  assign o_bin      = w_bin_full[width-1:0];

endmodule

// File: rtl/read_pointer_handler.sv
// Async FIFO read-side pointer logic in the clk_rx domain.
// Ports: clk_rx/rst_rx, pop in, synced gray write ptr in;
// empty, almost_empty, read_level, read_pointer,
// registered gray read ptr and sticky underflow_err out.
module read_pointer_handler
  import fifo_pkg::*;
#(
  parameter int pointer_width      = 3,
  parameter int almost_empty_level = 1
) (
  input  logic                   clk_rx,
  input  logic                   rst_rx,
  input  logic                   pop,
  input  logic [pointer_width:0] synced_graycoded_write_pointer,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [pointer_width:0] read_level,
  output logic [pointer_width-1:0] read_pointer,
  output logic [pointer_width:0] graycoded_read_pointer,
  output logic                   underflow_err
);

  localparam int CW = pointer_width + 1;
  localparam logic [CW-1:0] AE_LVL = CW'(almost_empty_level);

  logic [CW-1:0]     r_read_counter;
  logic [CW-1:0]     r_gray_rd;
  logic              r_underflow;
  logic [CW-1:0]     w_gray_rd;
  logic [CW-1:0]     w_wr_bin;
  logic [GRAY_W-1:0] w_gray_full;

  assign w_gray_full = gray_encode(GRAY_W'(r_read_counter));
  assign w_gray_rd   = w_gray_full[CW-1:0];

  graycode_decoder #(
    .width (CW)
  ) u_wr_dec (
    .i_gray (synced_graycoded_write_pointer),
    .o_bin  (w_wr_bin)
  );

  // Full-width compare: MSB distinguishes empty from a full lap.
  assign empty        = (w_gray_rd == synced_graycoded_write_pointer);
  assign read_level   = w_wr_bin - r_read_counter;
  assign almost_empty = (read_level <= AE_LVL);
  assign read_pointer = r_read_counter[pointer_width-1:0];

  assign graycoded_read_pointer = r_gray_rd;
  assign underflow_err          = r_underflow;

  always_ff @(posedge clk_rx) begin
    if (rst_rx) begin
      r_read_counter <= '0;
      r_gray_rd      <= '0;
      r_underflow    <= 1'b0;
    end else begin
      if (pop && !empty) begin
        r_read_counter <= r_read_counter + CW'(1);
      end
      r_gray_rd <= w_gray_rd;
      if (pop && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_read_pointer_handler.sv
// Randomized bench for read_pointer_handler against
// an occupancy-based reference model.
module tb_read_pointer_handler;

  localparam int PW = 3;
  localparam int D  = 1 << PW;
  localparam int M  = 2 * D;
  localparam int AE = 1;

  logic          clk_rx = 1'b0;
  logic          rst_rx;
  logic          pop;
  logic [PW:0]   sync_g;
  logic          empty;
  logic          almost_empty;
  logic [PW:0]   read_level;
  logic [PW-1:0] read_pointer;
  logic [PW:0]   graycoded_read_pointer;
  logic          underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  int m_rd  = 0;
  int m_wr  = 0;
  int m_gq  = 0;
  bit m_uf  = 0;

  always #5 clk_rx = ~clk_rx;

  read_pointer_handler #(
    .pointer_width      (PW),
    .almost_empty_level (AE)
  ) dut (
    .clk_rx                         (clk_rx),
    .rst_rx                         (rst_rx),
    .pop                            (pop),
    .synced_graycoded_write_pointer (sync_g),
    .empty                          (empty),
    .almost_empty                   (almost_empty),
    .read_level                     (read_level),
    .read_pointer                   (read_pointer),
    .graycoded_read_pointer         (graycoded_read_pointer),
    .underflow_err                  (underflow_err)
  );

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit p, input int wr, input bit rst);
    int lvl;
    @(negedge clk_rx);
    m_wr   = wr % M;
    pop    = p;
    rst_rx = rst;
    sync_g = (PW+1)'(gray(m_wr));
    #1;
    lvl = (m_wr - m_rd + M) % M;
    chk("empty",   32'(empty),        32'(lvl == 0));
    chk("ae",      32'(almost_empty), 32'(lvl <= AE));
    chk("level",   32'(read_level),   32'(lvl));
    chk("lvl_ok",  32'(read_level <= D), 32'd1);
    chk("rptr",    32'(read_pointer), 32'(m_rd % D));
    chk("gray_rd", 32'(graycoded_read_pointer), 32'(m_gq));
    chk("uflow",   32'(underflow_err), 32'(m_uf));
    @(posedge clk_rx);
    if (rst) begin
      m_rd = 0;
      m_gq = 0;
      m_uf = 0;
    end else begin
      m_gq = gray(m_rd);
      if (p && lvl != 0) m_rd = (m_rd + 1) % M;
      if (p && lvl == 0) m_uf = 1;
    end
  endtask

  initial begin
    int wr;
    int lvl;
    rst_rx = 1'b1;
    pop    = 1'b0;
    sync_g = '0;
    repeat (2) @(posedge clk_rx);
    step(0, 0, 0);
    // Fill to 1,2,3 without popping.
    step(0, 1, 0);
    step(0, 2, 0);
    step(0, 3, 0);
    // Full FIFO, drain with 8 pops.
    for (int i = 0; i < D; i++) step(1, D, 0);
    step(0, D, 0);
    step(0, D, 0);
    chk("gray_full", 32'(graycoded_read_pointer), 32'b1100);
    // Underflow is sticky through traffic.
    step(1, D, 0);
    step(0, D + 3, 0);
    step(1, D + 3, 0);
    step(1, D + 3, 0);
    chk("uf_sticky", 32'(underflow_err), 32'd1);
    // Random traffic with wraps.
    for (int i = 0; i < 300; i++) begin
      wr  = m_wr;
      lvl = (m_wr - m_rd + M) % M;
      if ($urandom % 3 == 0) wr = m_wr + $urandom_range(D - lvl, 0);
      step(1'($urandom % 2), wr, 0);
    end
    // Drain then jump 2 -> 6 in one step.
    while (((m_wr - m_rd + M) % M) != 0) step(1, m_wr, 0);
    step(0, m_rd + 2, 0);
    step(0, m_rd + 6, 0);
    step(0, m_wr, 0);
    // Reset mid-pop, synced pointer back to 0.
    step(1, m_wr, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
